vga_scroll_addr_gen: RTL

Parametrised frame-buffer read-address generator for the VGA path. It maps the display raster (h_cnt, v_cnt) onto a down-scaled source image, applying independent horizontal and vertical scroll offsets. Offsets wrap toroidally and update only at frame boundaries, so no tearing occurs. It sits between the VGA sync counter and the frame-buffer BRAM read port, and has a fixed 2-cycle pipeline latency.

---
 rtl/vga_scroll_addr_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_scroll_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_scroll_addr_gen
//  Description : Frame-buffer read-address generator for the VGA path. Maps
//                the raster (h_cnt, v_cnt) onto a down-scaled source image
//                with toroidally wrapping horizontal/vertical scroll offsets
//                that change only at frame boundaries. Fixed 2-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scroll_addr_gen #(
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned POS_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              dir_h,
    input  logic              dir_v,
    input  logic [3:0]        step,
    input  logic [7:0]        frame_div,
    input  logic              frame_start,
    input  logic              valid,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              addr_valid,
    output logic [POS_W-1:0]  x_off,
    output logic [POS_W-1:0]  y_off
);

    // One extra bit so offset + step / offset + coordinate cannot overflow
    // before the wrap compare.
    localparam int unsigned         c_sum_w      = POS_W + 1;
    localparam logic [c_sum_w-1:0]  c_img_w      = c_sum_w'(IMG_W);
    localparam logic [c_sum_w-1:0]  c_img_h      = c_sum_w'(IMG_H);
    localparam logic [ADDR_W-1:0]   c_img_w_addr = ADDR_W'(IMG_W);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [7:0]        div_cnt_q,    div_cnt_d;
    logic [POS_W-1:0]  x_off_q,      x_off_d;
    logic [POS_W-1:0]  y_off_q,      y_off_d;
    logic [POS_W-1:0]  sx_q,         sx_d;
    logic [POS_W-1:0]  sy_q,         sy_d;
    logic              v1_q,         v1_d;
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic              addr_valid_q, addr_valid_d;

    // Combinational helpers
    logic               w_tick;
    logic [c_sum_w-1:0] w_hs;
    logic [c_sum_w-1:0] w_vs;
    logic [c_sum_w-1:0] w_sx_sum;
    logic [c_sum_w-1:0] w_sy_sum;
    logic [c_sum_w-1:0] w_sx_wrap;
    logic [c_sum_w-1:0] w_sy_wrap;

    // ------------------------------------------------------------------------
    // Move an offset by 'stp' in the requested direction, wrapping modulo
    // 'img' with a single compare/subtract (stp is always below img).
    // ------------------------------------------------------------------------
    function automatic logic [POS_W-1:0] step_wrap(
        input logic [POS_W-1:0]   off,
        input logic [3:0]         stp,
        input logic [c_sum_w-1:0] img,
        input logic               dec
    );
        logic [c_sum_w-1:0] off_e;
        logic [c_sum_w-1:0] stp_e;
        logic [c_sum_w-1:0] t;
        off_e = {1'b0, off};
        stp_e = c_sum_w'(stp);
        if (dec) begin
            if (off_e < stp_e) begin
                t = off_e + img - stp_e;
            end else begin
                t = off_e - stp_e;
            end
        end else begin
            t = off_e + stp_e;
            if (t >= img) begin
                t = t - img;
            end
        end
        return t[POS_W-1:0];
    endfunction

    // Frame divider and offset update: offsets move only on a divider tick,
    // sampling mode/dir/step at that instant.
    always_comb begin
        div_cnt_d = div_cnt_q;
        x_off_d   = x_off_q;
        y_off_d   = y_off_q;
        w_tick    = 1'b0;
        if (frame_start && en) begin
            if (div_cnt_q == frame_div) begin
                div_cnt_d = 8'd0;
                w_tick    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
        if (w_tick) begin
            if (mode[1]) begin
                x_off_d = step_wrap(x_off_q, step, c_img_w, dir_h);
            end
            if (mode[0]) begin
                y_off_d = step_wrap(y_off_q, step, c_img_h, dir_v);
            end
        end
    end

    // Stage 1: scaled raster coordinate plus the current (pre-update) offset,
    // folded back into the image with one conditional subtract.
    always_comb begin
        w_hs      = c_sum_w'(h_cnt >> SCALE_SHIFT);
        w_vs      = c_sum_w'(v_cnt >> SCALE_SHIFT);
        w_sx_sum  = w_hs + {1'b0, x_off_q};
        w_sy_sum  = w_vs + {1'b0, y_off_q};
        w_sx_wrap = (w_sx_sum >= c_img_w) ? (w_sx_sum - c_img_w) : w_sx_sum;
        w_sy_wrap = (w_sy_sum >= c_img_h) ? (w_sy_sum - c_img_h) : w_sy_sum;
        sx_d      = w_sx_wrap[POS_W-1:0];
        sy_d      = w_sy_wrap[POS_W-1:0];
        v1_d      = valid;
    end

    // Stage 2: linear address; forced to zero for blanking cycles.
    always_comb begin
        pixel_addr_d = '0;
        addr_valid_d = v1_q;
        if (v1_q) begin
            pixel_addr_d = ADDR_W'(sy_q) * c_img_w_addr + ADDR_W'(sx_q);
        end
    end

    // State register: asynchronous reset clears offsets, divider and every
    // in-flight pipeline entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= 8'd0;
            x_off_q      <= '0;
            y_off_q      <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            v1_q         <= 1'b0;
            pixel_addr_q <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            x_off_q      <= x_off_d;
            y_off_q      <= y_off_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            v1_q         <= v1_d;
            pixel_addr_q <= pixel_addr_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign pixel_addr = pixel_addr_q;
    assign addr_valid = addr_valid_q;
    assign x_off      = x_off_q;
    assign y_off      = y_off_q;

endmodule
`default_nettype wire
